// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage datapath.
// Drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and
// flush/bubble controls plus the PC enable. It resolves load-use stalls,
// data-memory wait states, branch flushes and halt/resume.
// All control outputs are a Mealy decode of the registered state and the
// current inputs, so stall and flush decisions take effect in the same cycle.
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RUN        | normal flow; halt, memory stall, branch flush, load-use stall
// MEM_WAIT   | data memory busy; pipeline frozen, MEM/WB bubbled
// FLUSH      | apply a branch that resolved while memory was busy
// HALT       | pipeline frozen until a resume pulse

module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock_i,
    input  logic        nreset_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    input  logic        load_use_i,
    input  logic        branch_taken_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        mem_wb_bubble_o,
    output logic [1:0]  state_o,
    output logic        mem_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    // Control vector bit order:
    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [7:0] CTL_OFF   = 8'b0000_0_000;
    localparam logic [7:0] CTL_ADV   = 8'b1111_1_000;
    localparam logic [7:0] CTL_STALL = 8'b0000_1_001;
    localparam logic [7:0] CTL_BR    = 8'b1111_1_110;
    localparam logic [7:0] CTL_LU    = 8'b0011_1_010;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_HALT     = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          branch_pending_q, branch_pending_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_timeout_q, mem_timeout_d;
    logic [7:0]    ctl_d;
    logic [7:0]    ctl_gated;
    logic          mem_stall;

    assign mem_stall = mem_req_i & ~mem_ready_i;

    // State register and sticky status; async reset discards any pending branch.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q          <= ST_RUN;
            branch_pending_q <= 1'b0;
            wait_cnt_q       <= '0;
            mem_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            branch_pending_q <= branch_pending_d;
            wait_cnt_q       <= wait_cnt_d;
            mem_timeout_q    <= mem_timeout_d;
        end
    end

    // Next-state and control decode, priority ordered within each state.
    always_comb begin
        state_d          = state_q;
        branch_pending_d = branch_pending_q;
        wait_cnt_d       = wait_cnt_q;
        mem_timeout_d    = mem_timeout_q;
        ctl_d            = CTL_OFF;
        case (state_q)
            ST_RUN: begin
                if (halt_req_i) begin
                    ctl_d   = CTL_OFF;
                    state_d = ST_HALT;
                end else if (mem_stall) begin
                    ctl_d      = CTL_STALL;
                    wait_cnt_d = CNT_ONE;
                    state_d    = ST_MEM_WAIT;
                end else if (branch_taken_i) begin
                    ctl_d = CTL_BR;
                end else if (load_use_i) begin
                    ctl_d = CTL_LU;
                end else begin
                    ctl_d = CTL_ADV;
                end
            end
            ST_MEM_WAIT: begin
                // A branch resolving here is held until memory completes.
                if (branch_taken_i) begin
                    branch_pending_d = 1'b1;
                end
                if (mem_ready_i) begin
                    ctl_d      = CTL_ADV;
                    wait_cnt_d = '0;
                    state_d    = (branch_pending_q | branch_taken_i) ? ST_FLUSH : ST_RUN;
                end else if (wait_cnt_q == CNT_LAST) begin
                    ctl_d         = CTL_STALL;
                    wait_cnt_d    = '0;
                    mem_timeout_d = 1'b1;
                    state_d       = ST_HALT;
                end else begin
                    ctl_d      = CTL_STALL;
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                // A fresh memory stall wins; the flush is retried after it.
                if (mem_stall) begin
                    ctl_d      = CTL_STALL;
                    wait_cnt_d = CNT_ONE;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    ctl_d            = CTL_BR;
                    branch_pending_d = 1'b0;
                    state_d          = halt_req_i ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                ctl_d = CTL_OFF;
                if (resume_i) begin
                    mem_timeout_d = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                ctl_d   = CTL_OFF;
                state_d = ST_RUN;
            end
        endcase
    end

    // Controls are forced low for as long as reset is held.
    assign ctl_gated = nreset_i ? ctl_d : CTL_OFF;

    assign {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
            if_id_flush_o, id_ex_flush_o, mem_wb_bubble_o} = ctl_gated;
    assign state_o       = state_q;
    assign mem_timeout_o = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; HALT cycles are not counted as stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctl_gated[7] && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ctl_gated[1] && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage datapath. It drives the enable and flush/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves load-use stalls, data-memory wait states, branch flushes and halt/resume. It sits beside the datapath in the SoC core and is the only source of pipeline-register stall and flush control.

## Interface
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before a timeout halt; must be ≥2.
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- mem_req  in  1  the MEM-stage instruction is a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- load_use  in  1  the ID instruction reads a register written by the load in EX.
- branch_taken  in  1  single-cycle pulse: the branch in EX is resolved taken.
- halt_req  in  1  level; requests a pipeline halt.
- resume  in  1  pulse; leaves HALT.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
- if_id_flush, id_ex_flush  out  1 each  the register loads all-zero (NOP, wen=0) on the next edge; this overrides its en.
- mem_wb_bubble  out  1  MEM/WB loads all-zero (reg_file_wen=0) on the next edge.
- state  out  2  RUN=00, MEM_WAIT=01, FLUSH=10, HALT=11.
- mem_timeout  out  1  sticky flag: a memory access timed out.

## Operation
- Registered state: FSM state, branch_pending, wait counter of width $clog2(MEM_TIMEOUT), and mem_timeout. All outputs are a combinational (Mealy) decode of the state and inputs.
- "Stall" outputs: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_en=1 and mem_wb_bubble=1.
- "Advance" outputs: every enable is 1 and every flush/bubble is 0.
- RUN. Conditions are evaluated in priority order:
  1. halt_req: all enables 0; next state HALT.
  2. mem_req & !mem_ready: stall outputs; wait counter is set to 1; next state MEM_WAIT.
  3. branch_taken: advance, plus if_id_flush=1 and id_ex_flush=1.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1; all other enables 1.
  5. Otherwise: advance. mem_req with mem_ready=1 is a zero-wait access and causes no stall.
- MEM_WAIT:
  - Stall outputs.
  - A branch_taken pulse sets branch_pending. halt_req and load_use are ignored.
  - mem_ready=1: advance this cycle (no bubble). Next state is FLUSH if branch_pending (or branch_taken this cycle) is set, otherwise RUN.
  - mem_ready=0 and counter = MEM_TIMEOUT-1: set mem_timeout; next state HALT.
  - Otherwise the counter increments.
- FLUSH: advance, plus if_id_flush=1 and id_ex_flush=1. branch_pending clears.
  - If mem_req & !mem_ready: stall outputs take precedence, no flush is applied and branch_pending stays set; next state MEM_WAIT.
  - Else if halt_req: next state HALT.
  - Else: next state RUN.
- HALT: all enables 0, no flushes. resume=1 clears mem_timeout; next state RUN. halt_req still high when resume arrives re-enters HALT on the following cycle.
- While nreset is low, every enable and flush output is forced to 0.

## Timing
- Reset values: state=RUN, branch_pending=0, counter=0, mem_timeout=0. The async assert takes effect immediately; registers update on the first rising edge after deassert.
- Stall and flush decisions take effect in the same cycle as their inputs, with 0-cycle latency. State changes on the next edge.
- A load-use stall lasts exactly 1 cycle per assertion of load_use.
- Memory access with N wait cycles: N stall cycles, then the advance cycle. N≥MEM_TIMEOUT → HALT, with mem_timeout=1 from cycle MEM_TIMEOUT+1 onward.
- A branch resolved during MEM_WAIT is applied in the first FLUSH cycle after memory completes, never lost.
- A reset asserted in any state returns to RUN with outputs 0. Any pending branch is discarded.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds two ports, both reset to 0.
  - stall_cnt  out  16  counts cycles with pc_en=0 while not in HALT; saturates at 0xFFFF.
  - flush_cnt  out  16  counts cycles with id_ex_flush=1; saturates at 0xFFFF.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: nreset low mid-MEM_WAIT → state=00, all outputs 0 immediately; after release with idle inputs, all enables =1.
- load_use=1 for one cycle in RUN → pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; then advance.
- mem_req=1, mem_ready low for 3 cycles → 3 cycles of stall with mem_wb_bubble=1; 4th cycle advances; state returns to 00.
- branch_taken pulse in MEM_WAIT cycle 2, mem_ready at cycle 4 → one FLUSH cycle (state=10, if_id_flush=id_ex_flush=1), then RUN.
- mem_ready never asserted, MEM_TIMEOUT=16 → HALT after 16 wait cycles, mem_timeout=1; resume pulse → RUN, mem_timeout=0.
- branch_taken and load_use both high in RUN → flushes asserted, pc_en=1 (branch wins); with PIPE_CTRL_PERF_EN, flush_cnt increments by 1.
